posit_cmd_sched: RTL and testbench
==================================

POSIT_CMD_SCHED -- requirements
Module: posit_cmd_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of one command word as written by MMIO.
REQ-002 SHALL have parameter DEPTH, default 8, command FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 16, maximum issued commands without a completed write; range 1..255.
REQ-004 SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: cmd_valid  input  1  one-cycle pulse; an MMIO command write is present; cannot be back-pressured.
REQ-007 SHALL have port: cmd_data  input  DATA_W  command word, qualified by cmd_valid.
REQ-008 SHALL have port: fu_req_valid  output  1  a command is offered to the posit FU.
REQ-009 SHALL have port: fu_req_ready  input  1  the FU accepts the offered command.
REQ-010 SHALL have port: fu_req_data  output  DATA_W  head-of-FIFO command word.
REQ-011 SHALL have port: wr_done  input  1  one-cycle pulse; one FU result write issued to host memory.
REQ-012 SHALL have port: drain_req  input  1  one-cycle pulse; requests a drain.
REQ-013 SHALL have port: drain_done  output  1  one-cycle pulse; the drain has completed.
REQ-014 SHALL have port: occupancy  output  $clog2(DEPTH)+1  FIFO entry count.
REQ-015 SHALL have port: inflight  output  8  count of commands issued but not yet written.
REQ-016 SHALL have port: drop_count  output  16  saturating count of dropped commands.
REQ-017 SHALL have port: underflow_err  output  1  sticky flag: wr_done arrived while inflight was 0.
REQ-018 SHALL have port: idle  output  1  high when state is IDLE.

Function
REQ-019 SHALL buffer commands in a DEPTH-entry FIFO; a push occurs when cmd_valid=1, the FIFO is not full, and the state is not DRAIN.
REQ-020 SHALL evaluate "full" from the start-of-cycle occupancy; a push while full and a same-cycle pop still drops the push.
REQ-021 SHALL count every cmd_valid that does not push (FIFO full or state DRAIN) in drop_count, saturating at 16'hFFFF.
REQ-022 SHALL drive fu_req_valid = (occupancy!=0) && (inflight<MAX_INFLIGHT), using registered values only (no combinational path from cmd_valid).
REQ-023 SHALL drive fu_req_data from the FIFO head entry, held stable while fu_req_valid=1 and fu_req_ready=0.
REQ-024 SHALL pop the FIFO and increment inflight on each cycle with fu_req_valid && fu_req_ready.
REQ-025 SHALL assert fu_req_valid no earlier than the cycle after the push of a command into an empty FIFO (1-cycle minimum latency).
REQ-026 SHALL decrement inflight on wr_done when inflight>0; on wr_done with inflight=0 it SHALL hold inflight at 0 and set underflow_err.
REQ-027 SHALL leave inflight unchanged when an issue and a wr_done occur in the same cycle.
REQ-028 SHALL allow a push and a pop in the same cycle when the FIFO is not full, leaving occupancy unchanged.
REQ-029 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-030 SHALL implement an FSM with states IDLE, BUSY and DRAIN.
REQ-031 SHALL transition IDLE->BUSY on a push.
REQ-032 SHALL transition BUSY->IDLE when occupancy=0, inflight=0 and no push occurs this cycle.
REQ-033 SHALL transition IDLE->DRAIN or BUSY->DRAIN on drain_req; drain_req takes priority over a simultaneous push, and that push is dropped and counted.
REQ-034 SHALL continue issuing commands in DRAIN and SHALL reject all new commands.
REQ-035 SHALL transition DRAIN->IDLE when occupancy=0 and inflight=0 (evaluated after this cycle's updates), pulsing drain_done for exactly one cycle on that transition.
REQ-036 SHALL complete a drain requested with no pending work as IDLE->DRAIN->IDLE, with drain_done one cycle after drain_req.
REQ-037 SHALL ignore drain_req while already in DRAIN.

Reset
REQ-038 SHALL, with reset=1 at a clock edge, clear both FIFO pointers, occupancy, inflight, drop_count and underflow_err, and set the state to IDLE.
REQ-039 SHALL hold fu_req_valid=0, drain_done=0 and idle=1 from the first edge with reset=1, including when reset is asserted mid-drain or with commands in flight.
REQ-040 SHALL discard FIFO contents on reset; no command issues after reset until a new push.

Verification
REQ-041 SHALL be verified by this directed scenario: push 3 commands (0x11, 0x22, 0x33) with fu_req_ready=1 -> issued in order one per cycle, first one cycle after its push, inflight=3, state BUSY.
REQ-042 SHALL be verified by this directed scenario: fu_req_ready=0, push DEPTH+2 commands -> occupancy=DEPTH, drop_count=2, fu_req_data equals the first command and stays stable.
REQ-043 SHALL be verified by this directed scenario: MAX_INFLIGHT=2, 4 commands queued, ready=1 -> 2 issue, then fu_req_valid=0; one wr_done -> exactly one more issue.
REQ-044 SHALL be verified by this directed scenario: wr_done in the same cycle as an issue -> inflight unchanged; wr_done with inflight=0 -> underflow_err=1 and inflight stays 0.
REQ-045 SHALL be verified by this directed scenario: drain_req with 2 queued and 1 inflight, plus cmd_valid during drain -> that command is dropped and drop_count increments; after 3 wr_done, drain_done pulses once and idle=1.
REQ-046 SHALL be verified by this directed scenario: reset asserted mid-drain with occupancy=3 -> next cycle occupancy=0, inflight=0, idle=1, fu_req_valid=0, and no drain_done pulse.

Source files
------------

// File: rtl/posit_cmd_sched.sv
// posit_cmd_sched: MMIO command FIFO feeding a posit functional unit.
// Commands are queued, issued in order while the outstanding-write budget
// allows, and retired by wr_done. A drain request stops intake and waits
// until both the queue and the outstanding writes reach zero.
module posit_cmd_sched #(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 8,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     fu_req_valid,
  input  logic                     fu_req_ready,
  output logic [DATA_W-1:0]        fu_req_data,
  input  logic                     wr_done,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [7:0]               inflight,
  output logic [15:0]              drop_count,
  output logic                     underflow_err,
  output logic                     idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE  = {{(OCC_W-1){1'b0}}, 1'b1};
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       INF_MAX  = 8'(MAX_INFLIGHT);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [OCC_W-1:0]  occ_r;
  logic [OCC_W-1:0]  occ_nxt_s;
  logic [7:0]        inflight_r;
  logic [7:0]        inflight_nxt_s;
  logic [15:0]       drop_r;
  logic              underflow_r;
  logic              drain_done_r;
  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;

  logic full_s;
  logic fu_valid_s;
  logic drain_accept_s;
  logic push_s;
  logic drop_s;
  logic issue_s;
  logic underflow_set_s;
  logic drain_done_nxt_s;

  // Issue qualification uses only registered state, so cmd_valid never reaches fu_req_valid.
  always_comb begin
    full_s     = (occ_r == OCC_FULL);
    fu_valid_s = (occ_r != OCC_ZERO) && (inflight_r < INF_MAX);
  end

  // Per-cycle events; an accepted drain request wins over a simultaneous push.
  always_comb begin
    drain_accept_s = drain_req && (state_r != ST_DRAIN);
    push_s         = cmd_valid && !full_s && (state_r != ST_DRAIN) && !drain_accept_s;
    drop_s         = cmd_valid && !push_s;
    issue_s        = fu_valid_s && fu_req_ready;
  end

  // Next FIFO occupancy; push and pop together leave it unchanged.
  always_comb begin
    occ_nxt_s = occ_r;
    if (push_s && !issue_s) begin
      occ_nxt_s = occ_r + OCC_ONE;
    end else if (issue_s && !push_s) begin
      occ_nxt_s = occ_r - OCC_ONE;
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // Next outstanding-write count; a retire with nothing outstanding flags underflow.
  always_comb begin
    inflight_nxt_s  = inflight_r;
    underflow_set_s = 1'b0;
    if (issue_s && wr_done) begin
      inflight_nxt_s = inflight_r;
    end else if (issue_s) begin
      inflight_nxt_s = inflight_r + 8'd1;
    end else if (wr_done) begin
      if (inflight_r != 8'd0) begin
        inflight_nxt_s = inflight_r - 8'd1;
      end else begin
        inflight_nxt_s  = 8'd0;
        underflow_set_s = 1'b1;
      end
    end else begin
      inflight_nxt_s = inflight_r;
    end
  end

  // Scheduler FSM; drain completion looks at the post-update counts.
  always_comb begin
    state_nxt_s      = state_r;
    drain_done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (drain_accept_s) begin
          state_nxt_s = ST_DRAIN;
        end else if (push_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (drain_accept_s) begin
          state_nxt_s = ST_DRAIN;
        end else if ((occ_r == OCC_ZERO) && (inflight_r == 8'd0) && !push_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DRAIN: begin
        if ((occ_nxt_s == OCC_ZERO) && (inflight_nxt_s == 8'd0)) begin
          state_nxt_s      = ST_IDLE;
          drain_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Command storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= cmd_data;
    end
  end

  // Control state, pointers (wrapping naturally at DEPTH) and status counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      occ_r        <= OCC_ZERO;
      inflight_r   <= 8'd0;
      drop_r       <= 16'd0;
      underflow_r  <= 1'b0;
      drain_done_r <= 1'b0;
      state_r      <= ST_IDLE;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s && (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'd1;
      end
      if (underflow_set_s) begin
        underflow_r <= 1'b1;
      end
      occ_r        <= occ_nxt_s;
      inflight_r   <= inflight_nxt_s;
      drain_done_r <= drain_done_nxt_s;
      state_r      <= state_nxt_s;
    end
  end

  assign fu_req_valid  = fu_valid_s;
  assign fu_req_data   = mem_r[rd_ptr_r];
  assign drain_done    = drain_done_r;
  assign occupancy     = occ_r;
  assign inflight      = inflight_r;
  assign drop_count    = drop_r;
  assign underflow_err = underflow_r;
  assign idle          = (state_r == ST_IDLE);

endmodule

// File: tb/tb_posit_cmd_sched.sv
// Directed bench for posit_cmd_sched: a default instance (u0) and one with
// MAX_INFLIGHT=2 (u1). Expected issue order is queued at push time and a
// negedge monitor compares every handshake against it.
module tb_posit_cmd_sched;
  localparam int DW = 64;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          cmd_valid0, fu_req_valid0, fu_req_ready0, wr_done0, drain_req0, drain_done0;
  logic [DW-1:0] cmd_data0, fu_req_data0;
  logic [3:0]    occupancy0;
  logic [7:0]    inflight0;
  logic [15:0]   drop_count0;
  logic          underflow_err0, idle0;

  logic          cmd_valid1, fu_req_valid1, fu_req_ready1, wr_done1, drain_req1, drain_done1;
  logic [DW-1:0] cmd_data1, fu_req_data1;
  logic [3:0]    occupancy1;
  logic [7:0]    inflight1;
  logic [15:0]   drop_count1;
  logic          underflow_err1, idle1;

  posit_cmd_sched #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_INFLIGHT(16)) u0 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid0), .cmd_data(cmd_data0),
    .fu_req_valid(fu_req_valid0), .fu_req_ready(fu_req_ready0), .fu_req_data(fu_req_data0),
    .wr_done(wr_done0), .drain_req(drain_req0), .drain_done(drain_done0),
    .occupancy(occupancy0), .inflight(inflight0), .drop_count(drop_count0),
    .underflow_err(underflow_err0), .idle(idle0));

  posit_cmd_sched #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_INFLIGHT(2)) u1 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid1), .cmd_data(cmd_data1),
    .fu_req_valid(fu_req_valid1), .fu_req_ready(fu_req_ready1), .fu_req_data(fu_req_data1),
    .wr_done(wr_done1), .drain_req(drain_req1), .drain_done(drain_done1),
    .occupancy(occupancy1), .inflight(inflight1), .drop_count(drop_count1),
    .underflow_err(underflow_err1), .idle(idle1));

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int drain_pulses0 = 0;
  int issues1 = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor for u0 issues and drain_done pulses.
  always @(negedge clock) begin
    if (fu_req_valid0 === 1'b1 && fu_req_ready0 === 1'b1) begin
      if (exp_q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u0_unexpected_issue: got data 0x%0h, expected no issue", fu_req_data0);
      end else begin
        check("u0_issue_data", fu_req_data0, exp_q0.pop_front());
      end
    end
    if (drain_done0 === 1'b1) drain_pulses0++;
  end

  // Scoreboard monitor for u1 issues.
  always @(negedge clock) begin
    if (fu_req_valid1 === 1'b1 && fu_req_ready1 === 1'b1) begin
      issues1++;
      if (exp_q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u1_unexpected_issue: got data 0x%0h, expected no issue", fu_req_data1);
      end else begin
        check("u1_issue_data", fu_req_data1, exp_q1.pop_front());
      end
    end
  end

  // Push one command into u0 on the next edge; accepted ones join the expected order.
  task automatic push0(input logic [DW-1:0] d, input bit accept);
    cmd_valid0 = 1'b1;
    cmd_data0  = d;
    if (accept) exp_q0.push_back(d);
    tick();
    cmd_valid0 = 1'b0;
  endtask

  task automatic wr_pulses0(input int n);
    for (int i = 0; i < n; i++) begin
      wr_done0 = 1'b1;
      tick();
    end
    wr_done0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cmd_valid0 = 1'b0; cmd_data0 = '0; fu_req_ready0 = 1'b0; wr_done0 = 1'b0; drain_req0 = 1'b0;
    cmd_valid1 = 1'b0; cmd_data1 = '0; fu_req_ready1 = 1'b0; wr_done1 = 1'b0; drain_req1 = 1'b0;
    tick();
    tick();
    check("rst_occupancy", occupancy0, 64'd0);
    check("rst_inflight", inflight0, 64'd0);
    check("rst_idle", idle0, 64'd1);
    check("rst_fu_valid", fu_req_valid0, 64'd0);
    check("rst_drop", drop_count0, 64'd0);
    check("rst_underflow", underflow_err0, 64'd0);
    reset = 1'b0;
    tick();

    // In-order issue, one per cycle, one cycle after each push.
    fu_req_ready0 = 1'b1;
    check("s1_valid_before_push", fu_req_valid0, 64'd0);
    cmd_valid0 = 1'b1; cmd_data0 = 64'h11; exp_q0.push_back(64'h11);
    tick();
    check("s1_valid_after_push", fu_req_valid0, 64'd1);
    cmd_data0 = 64'h22; exp_q0.push_back(64'h22);
    tick();
    check("s1_occ_push_pop", occupancy0, 64'd1);
    cmd_data0 = 64'h33; exp_q0.push_back(64'h33);
    tick();
    cmd_valid0 = 1'b0;
    tick();
    check("s1_inflight", inflight0, 64'd3);
    check("s1_busy", idle0, 64'd0);
    check("s1_occ_empty", occupancy0, 64'd0);
    wr_pulses0(3);
    check("s1_inflight_retired", inflight0, 64'd0);
    tick();
    check("s1_back_to_idle", idle0, 64'd1);

    // Issue and retire in the same cycle; then underflow.
    push0(64'h44, 1'b1);
    tick();
    check("s4_inflight_one", inflight0, 64'd1);
    push0(64'h55, 1'b1);
    wr_done0 = 1'b1;
    tick();
    check("s4_issue_and_done", inflight0, 64'd1);
    tick();
    check("s4_inflight_zero", inflight0, 64'd0);
    check("s4_no_underflow_yet", underflow_err0, 64'd0);
    tick();
    wr_done0 = 1'b0;
    check("s4_underflow_set", underflow_err0, 64'd1);
    check("s4_inflight_held", inflight0, 64'd0);
    tick();

    // Overfill with the FU stalled; head stays put, extras are dropped.
    fu_req_ready0 = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push0(64'hA0 + 64'(i), i < DEPTH);
    end
    check("s2_occ_full", occupancy0, 64'd8);
    check("s2_drop_two", drop_count0, 64'd2);
    check("s2_head_data", fu_req_data0, 64'hA0);
    tick();
    tick();
    check("s2_head_stable", fu_req_data0, 64'hA0);
    check("s2_valid_held", fu_req_valid0, 64'd1);
    fu_req_ready0 = 1'b1;
    push0(64'hEE, 1'b0);
    check("s2_full_pop_drop", drop_count0, 64'd3);
    check("s2_occ_after_pop", occupancy0, 64'd7);
    for (int i = 0; i < 7; i++) tick();
    check("s2_occ_drained", occupancy0, 64'd0);
    check("s2_inflight_eight", inflight0, 64'd8);
    fu_req_ready0 = 1'b0;
    wr_pulses0(8);
    tick();
    check("s2_idle", idle0, 64'd1);

    // Drain with 2 queued and 1 in flight; a command during drain is dropped.
    fu_req_ready0 = 1'b1;
    push0(64'h61, 1'b1);
    push0(64'h62, 1'b1);
    fu_req_ready0 = 1'b0;
    push0(64'h63, 1'b1);
    check("s5_occ_two", occupancy0, 64'd2);
    check("s5_inflight_one", inflight0, 64'd1);
    drain_req0 = 1'b1;
    tick();
    drain_req0 = 1'b0;
    check("s5_in_drain", idle0, 64'd0);
    push0(64'h77, 1'b0);
    check("s5_drop_in_drain", drop_count0, 64'd4);
    fu_req_ready0 = 1'b1;
    tick();
    tick();
    fu_req_ready0 = 1'b0;
    check("s5_inflight_three", inflight0, 64'd3);
    check("s5_no_early_done", drain_pulses0, 64'd0);
    wr_pulses0(3);
    check("s5_drain_done", drain_done0, 64'd1);
    check("s5_idle", idle0, 64'd1);
    tick();
    check("s5_done_one_cycle", drain_done0, 64'd0);
    check("s5_pulse_count", drain_pulses0, 64'd1);

    // Drain with nothing pending: IDLE -> DRAIN -> IDLE.
    drain_req0 = 1'b1;
    tick();
    drain_req0 = 1'b0;
    check("s6_drain_state", idle0, 64'd0);
    check("s6_no_done_yet", drain_done0, 64'd0);
    tick();
    check("s6_done", drain_done0, 64'd1);
    check("s6_idle", idle0, 64'd1);
    tick();
    check("s6_pulse_count", drain_pulses0, 64'd2);
    check("s6_queue_empty", exp_q0.size(), 64'd0);

    // Inflight cap of 2 on u1.
    for (int i = 0; i < 4; i++) begin
      cmd_valid1 = 1'b1;
      cmd_data1  = 64'h81 + 64'(i);
      exp_q1.push_back(64'h81 + 64'(i));
      tick();
    end
    cmd_valid1 = 1'b0;
    fu_req_ready1 = 1'b1;
    tick();
    tick();
    check("s3_valid_capped", fu_req_valid1, 64'd0);
    check("s3_inflight_two", inflight1, 64'd2);
    check("s3_occ_two", occupancy1, 64'd2);
    tick();
    check("s3_issued_two", issues1, 64'd2);
    wr_done1 = 1'b1;
    tick();
    wr_done1 = 1'b0;
    tick();
    tick();
    check("s3_issued_three", issues1, 64'd3);
    check("s3_valid_capped_again", fu_req_valid1, 64'd0);
    check("s3_occ_one", occupancy1, 64'd1);

    // Reset in the middle of a drain with 3 queued.
    fu_req_ready0 = 1'b0;
    push0(64'h91, 1'b1);
    push0(64'h92, 1'b1);
    push0(64'h93, 1'b1);
    drain_req0 = 1'b1;
    tick();
    drain_req0 = 1'b0;
    check("s7_in_drain", idle0, 64'd0);
    check("s7_occ_three", occupancy0, 64'd3);
    reset = 1'b1;
    tick();
    exp_q0.delete();
    exp_q1.delete();
    check("s7_occ", occupancy0, 64'd0);
    check("s7_inflight", inflight0, 64'd0);
    check("s7_idle", idle0, 64'd1);
    check("s7_fu_valid", fu_req_valid0, 64'd0);
    check("s7_drain_done", drain_done0, 64'd0);
    check("s7_drop", drop_count0, 64'd0);
    check("s7_underflow", underflow_err0, 64'd0);
    check("s7_u1_inflight", inflight1, 64'd0);
    reset = 1'b0;
    fu_req_ready0 = 1'b1;
    tick();
    tick();
    tick();
    check("s7_no_issue_after_reset", fu_req_valid0, 64'd0);
    check("s7_no_done_pulse", drain_pulses0, 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
